// File: rtl/speed_pkg.sv
// Shared constants, FSM encoding and bit-timing helper for the speed report transmitter.
package speed_pkg;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_COMMA = 8'h2C;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam int RECORD_LEN = 9;
    localparam int NUM_DIGITS = 5;
    localparam int BCD_W      = 4 * NUM_DIGITS;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CONV  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } tx_state_t;

    function automatic int calc_clks_per_bit(input int sys_freq, input int baud);
        return sys_freq / baud;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one input bit per cycle, five BCD digits out.
module bin2bcd_seq
    import speed_pkg::*;
#(
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] bin,
    output logic             done,
    output logic [3:0]       d4,
    output logic [3:0]       d3,
    output logic [3:0]       d2,
    output logic [3:0]       d1,
    output logic [3:0]       d0
);

    localparam int SR_W  = BCD_W + WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

    logic [SR_W-1:0]  sr;
    logic [SR_W-1:0]  sr_adj;
    logic [CNT_W-1:0] cnt;

    // NOTE: combinational blocks assign a default first so no path leaves a latch.
    always_comb begin
        sr_adj = sr;
        for (int n = 0; n < NUM_DIGITS; n++) begin
            if (sr[WIDTH + 4*n +: 4] >= 4'd5)
                sr_adj[WIDTH + 4*n +: 4] = sr[WIDTH + 4*n +: 4] + 4'd3;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr   <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                sr  <= {{BCD_W{1'b0}}, bin};
                cnt <= CNT_INIT;
            end else if (cnt != '0) begin
                sr   <= {sr_adj[SR_W-2:0], 1'b0};
                cnt  <= cnt - CNT_W'(1);
                done <= (cnt == CNT_W'(1));
            end
        end
    end

    assign d0 = sr[WIDTH      +: 4];
    assign d1 = sr[WIDTH + 4  +: 4];
    assign d2 = sr[WIDTH + 8  +: 4];
    assign d3 = sr[WIDTH + 12 +: 4];
    assign d4 = sr[WIDTH + 16 +: 4];

endmodule

// File: rtl/speed_uart_tx.sv
// Sends one ASCII record "ddddd,n\r\n" per measurement over an 8N1 UART line,
// with a one-deep pending buffer for results arriving mid-record.
module speed_uart_tx
    import speed_pkg::*;
#(
    parameter int WIDTH_SPEED = 14,
    parameter int SYS_FREQ    = 50000000,
    parameter int BAUD        = 9600
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   done,
    input  logic [WIDTH_SPEED-1:0] speed,
    input  logic [1:0]             num_veh,
    output logic                   tx,
    output logic                   busy,
    output logic                   drop
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(SYS_FREQ, BAUD);
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]        LAST_BYTE = 4'(RECORD_LEN - 1);

    tx_state_t state, state_next;

    logic [BAUD_W-1:0]      baud_cnt;
    logic [2:0]             bit_idx;
    logic [3:0]             byte_idx;
    logic [1:0]             act_nveh;
    logic                   pend_valid;
    logic [WIDTH_SPEED-1:0] pend_speed;
    logic [1:0]             pend_nveh;

    logic                   bit_end;
    logic                   record_end;
    logic                   load_active;
    logic                   direct_capture;
    logic                   pend_write;
    logic [WIDTH_SPEED-1:0] conv_bin;
    logic [1:0]             load_nveh;
    logic                   bcd_done;
    logic [3:0]             d4, d3, d2, d1, d0;
    logic [7:0]             cur_byte;

    bin2bcd_seq #(.WIDTH(WIDTH_SPEED)) u_bcd (
        .clk   (clk),
        .reset (reset),
        .start (load_active),
        .bin   (conv_bin),
        .done  (bcd_done),
        .d4    (d4),
        .d3    (d3),
        .d2    (d2),
        .d1    (d1),
        .d0    (d0)
    );

    // A record starts from a fresh done in IDLE, or from the pending buffer,
    // which always wins so the older result is sent first.
    assign bit_end        = (baud_cnt == BAUD_LAST);
    assign record_end     = (state == ST_STOP) && bit_end && (byte_idx == LAST_BYTE);
    assign load_active    = ((state == ST_IDLE) && (pend_valid || done)) || (record_end && pend_valid);
    assign direct_capture = (state == ST_IDLE) && !pend_valid && done;
    assign pend_write     = done && !direct_capture;
    assign conv_bin       = pend_valid ? pend_speed : speed;
    assign load_nveh      = pend_valid ? pend_nveh : num_veh;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (pend_valid || done) state_next = ST_CONV;
            ST_CONV:  if (bcd_done) state_next = ST_START;
            ST_START: if (bit_end) state_next = ST_DATA;
            ST_DATA:  if (bit_end && (bit_idx == 3'd7)) state_next = ST_STOP;
            ST_STOP: begin
                if (bit_end) begin
                    if (byte_idx == LAST_BYTE) state_next = pend_valid ? ST_CONV : ST_IDLE;
                    else                       state_next = ST_START;
                end
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tx   = 1'b1;
        busy = (state != ST_IDLE) || pend_valid;
        case (state)
            ST_START: tx = 1'b0;
            ST_DATA:  tx = cur_byte[bit_idx];
            default:  tx = 1'b1;
        endcase
    end

    always_comb begin
        cur_byte = ASCII_LF;
        case (byte_idx)
            4'd0:    cur_byte = ASCII_0 + {4'd0, d4};
            4'd1:    cur_byte = ASCII_0 + {4'd0, d3};
            4'd2:    cur_byte = ASCII_0 + {4'd0, d2};
            4'd3:    cur_byte = ASCII_0 + {4'd0, d1};
            4'd4:    cur_byte = ASCII_0 + {4'd0, d0};
            4'd5:    cur_byte = ASCII_COMMA;
            4'd6:    cur_byte = ASCII_0 + {6'd0, act_nveh};
            4'd7:    cur_byte = ASCII_CR;
            default: cur_byte = ASCII_LF;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_cnt   <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            act_nveh   <= '0;
            pend_valid <= 1'b0;
            pend_speed <= '0;
            pend_nveh  <= '0;
            drop       <= 1'b0;
        end else begin
            drop <= pend_write && pend_valid && !load_active;

            if (pend_write) begin
                pend_valid <= 1'b1;
                pend_speed <= speed;
                pend_nveh  <= num_veh;
            end else if (load_active) begin
                pend_valid <= 1'b0;
            end

            if (load_active) act_nveh <= load_nveh;

            if (state inside {ST_START, ST_DATA, ST_STOP})
                baud_cnt <= bit_end ? '0 : baud_cnt + BAUD_W'(1);
            else
                baud_cnt <= '0;

            if ((state == ST_DATA) && bit_end) bit_idx <= bit_idx + 3'd1;

            if (state == ST_CONV)
                byte_idx <= '0;
            else if ((state == ST_STOP) && bit_end)
                byte_idx <= byte_idx + 4'd1;
        end
    end

endmodule

// File: tb/tb_speed_uart_tx.sv
// Directed and randomized bench for speed_uart_tx: per-cycle tx/busy/drop against a
// record-timeline model, plus a UART receiver checking the decoded byte stream.
module tb_speed_uart_tx;

    localparam int WS       = 14;
    localparam int CPB      = 10;
    localparam int CONV_LAT = WS + 1;
    localparam int REC_CYC  = CONV_LAT + 9 * 10 * CPB;

    logic          clk;
    logic          reset;
    logic          done;
    logic [WS-1:0] speed;
    logic [1:0]    num_veh;
    logic          tx;
    logic          busy;
    logic          drop;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int drop_cnt  = 0;
    bit chk_en    = 0;

    int    edge_n = 0;
    bit    m_active, m_pend_valid, exp_drop;
    int    m_start;
    string m_str;
    int    m_pend_spd, m_pend_nv;
    string exp_stream;

    logic [7:0] rx_q[$];
    logic [7:0] rx_byte;

    speed_uart_tx #(.WIDTH_SPEED(WS), .SYS_FREQ(1000), .BAUD(100)) dut (
        .clk     (clk),
        .reset   (reset),
        .done    (done),
        .speed   (speed),
        .num_veh (num_veh),
        .tx      (tx),
        .busy    (busy),
        .drop    (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic start_record(input int spd, input int nv);
        m_active = 1;
        m_start  = edge_n;
        m_str    = {$sformatf("%05d,%0d", spd, nv), "\r\n"};
        exp_stream = {exp_stream, m_str};
    endtask

    // Expected line level from the record text and its start edge.
    function automatic logic exp_tx();
        int off, k, bi, bp;
        logic [7:0] b;
        if (!m_active) return 1'b1;
        off = edge_n - m_start;
        if (off < CONV_LAT) return 1'b1;
        k  = off - CONV_LAT;
        bi = k / (10 * CPB);
        bp = (k % (10 * CPB)) / CPB;
        if (bi >= 9 || bp == 9) return 1'b1;
        if (bp == 0) return 1'b0;
        b = m_str[bi];
        return b[bp-1];
    endfunction

    // Reference model: one active record plus one pending slot, advanced per clock edge.
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_active = 0; m_pend_valid = 0; exp_drop = 0;
            end else begin
                edge_n++;
                exp_drop = 0;
                if (m_active && edge_n == m_start + REC_CYC) begin
                    m_active = 0;
                    if (m_pend_valid) begin
                        start_record(m_pend_spd, m_pend_nv);
                        m_pend_valid = 0;
                    end
                    if (done) begin
                        m_pend_valid = 1; m_pend_spd = int'(speed); m_pend_nv = int'(num_veh);
                    end
                end else if (!m_active) begin
                    if (m_pend_valid) begin
                        start_record(m_pend_spd, m_pend_nv);
                        m_pend_valid = 0;
                        if (done) begin
                            m_pend_valid = 1; m_pend_spd = int'(speed); m_pend_nv = int'(num_veh);
                        end
                    end else if (done) begin
                        start_record(int'(speed), int'(num_veh));
                    end
                end else if (done) begin
                    if (m_pend_valid) exp_drop = 1;
                    m_pend_valid = 1; m_pend_spd = int'(speed); m_pend_nv = int'(num_veh);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (drop === 1'b1) drop_cnt++;
            if (chk_en) begin
                check("tx", 32'(tx), 32'(exp_tx()));
                check("busy", 32'(busy), 32'(m_active || m_pend_valid));
                check("drop", 32'(drop), 32'(exp_drop));
            end
        end
    end

    // Independent 8N1 receiver sampling at bit centres.
    initial begin
        forever begin
            @(negedge clk);
            if (tx === 1'b0 && !reset) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    rx_byte[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                rx_q.push_back(rx_byte);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic send_done(input int spd, input int nv);
        @(negedge clk);
        speed   = WS'(spd);
        num_veh = 2'(nv);
        done    = 1'b1;
        @(negedge clk);
        done    = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic check_rx(input string exp, input string tag);
        check({tag, "_len"}, rx_q.size(), exp.len());
        for (int i = 0; i < exp.len() && i < rx_q.size(); i++)
            check($sformatf("%s[%0d]", tag, i), 32'(rx_q[i]), 32'(exp[i]));
        rx_q.delete();
    endtask

    initial begin
        int n, fall;
        reset = 1'b1; done = 1'b0; speed = '0; num_veh = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop", 32'(drop), 32'd0);
        reset = 1'b0;
        chk_en = 1;
        repeat (5) @(negedge clk);

        // 1: single record, latency and busy length
        send_done(120, 1);
        n = 0; fall = -1;
        while (busy && n < 2000) begin
            if (tx == 1'b0 && fall < 0) fall = n;
            @(negedge clk);
            n++;
        end
        check("s1_tx_fall", fall, 15);
        check("s1_busy_len", n, 915);
        check_rx("00120,1\r\n", "s1");

        // 2: max and zero values
        send_done(16383, 3);
        wait_idle(2000, "s2a_idle");
        send_done(0, 0);
        wait_idle(2000, "s2b_idle");
        check_rx("16383,3\r\n00000,0\r\n", "s2");

        // 3: one pending record, sent back-to-back
        drop_cnt = 0;
        send_done(50, 1);
        repeat (300) @(negedge clk);
        send_done(75, 2);
        wait_idle(2500, "s3_idle");
        check("s3_drops", drop_cnt, 0);
        check_rx("00050,1\r\n00075,2\r\n", "s3");

        // 4: pending overwritten, middle record lost
        drop_cnt = 0;
        send_done(50, 0);
        repeat (100) @(negedge clk);
        send_done(75, 1);
        repeat (50) @(negedge clk);
        send_done(90, 2);
        wait_idle(2500, "s4_idle");
        check("s4_drops", drop_cnt, 1);
        check_rx("00050,0\r\n00090,2\r\n", "s4");

        // 5: done on the last STOP cycle
        drop_cnt = 0;
        send_done(4321, 2);
        repeat (913) @(negedge clk);
        send_done(777, 3);
        n = 0;
        while (tx && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("s5_tx_fall", n, 16);
        wait_idle(2000, "s5_idle");
        check("s5_drops", drop_cnt, 0);
        check_rx("04321,2\r\n00777,3\r\n", "s5");

        // 6: asynchronous reset during byte 3 with a record pending
        send_done(9876, 2);
        repeat (100) @(negedge clk);
        send_done(555, 1);
        repeat (248) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("s6_async_tx", 32'(tx), 32'd1);
        check("s6_async_busy", 32'(busy), 32'd0);
        check("s6_async_drop", 32'(drop), 32'd0);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        check("s6_pend_cleared", 32'(busy), 32'd0);
        check("s6_idle_tx", 32'(tx), 32'd1);
        rx_q.delete();
        send_done(321, 1);
        wait_idle(2000, "s6_idle");
        check_rx("00321,1\r\n", "s6");

        // Randomized traffic, including overwrites and end-of-record collisions
        exp_stream = "";
        rx_q.delete();
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            done = ($urandom_range(0, 299) == 0);
            if (done) begin
                speed   = WS'($urandom_range(0, 16383));
                num_veh = 2'($urandom_range(0, 3));
            end
        end
        @(negedge clk);
        done = 1'b0;
        wait_idle(5000, "rand_idle");
        check_rx(exp_stream, "rand");

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/speed_uart_tx.md
Name: speed_uart_tx

Overview:
- Report transmitter for the vehicle speed measurement datapath.
- Consumes the datapath's result side (`speed`, `num_veh`, `done`) and sends one ASCII record per measurement over a UART TX line to the host/display.
- Record format is fixed: 5 speed digits with leading zeros, then `','`, one vehicle-count digit, CR, LF. That is 9 bytes, 8N1, LSB first.
- Sits next to the datapath at the top level; it is the outbound end of the measurement result interface.

Parameters:
- `WIDTH_SPEED`, 14: width of the speed input. Maximum value 16383, so 5 decimal digits.
- `SYS_FREQ`, 50000000: clock frequency in Hz.
- `BAUD`, 9600: UART bit rate. `CLKS_PER_BIT = SYS_FREQ/BAUD` (integer division), giving 5208 at the defaults.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `done`  in  1  one-cycle pulse: `speed` and `num_veh` are valid in this cycle.
- `speed`  in  `WIDTH_SPEED`  unsigned binary speed value.
- `num_veh`  in  2  vehicle count, 0..3.
- `tx`  out  1  UART serial output, idle high.
- `busy`  out  1  high while a record is converting or transmitting, or one is pending.
- `drop`  out  1  one-cycle pulse: the pending record was overwritten.

Behaviour:
- Interface: one clock (`clk`); reset (`reset`) is asynchronous and active-high.
- Reset values: `tx`=1, `busy`=0, `drop`=0, state IDLE, pending buffer empty, all counters 0. A reset mid-record aborts the record immediately: `tx` returns to 1 and any pending record is discarded.
- States: IDLE, CONV, START, DATA, STOP.
- Capture:
  - IDLE with `done`=1 at edge E0: latch `speed`/`num_veh` into the active registers, go to CONV, set `busy`=1 from E0.
  - In any other state, `done`=1 writes the pending buffer (`pend_valid`=1).
  - If `pend_valid` is already 1, the pending buffer is overwritten with the newest values and `drop` pulses for 1 cycle.
- CONV:
  - Sequential double-dabble binary-to-BCD, one input bit per cycle.
  - Takes exactly `WIDTH_SPEED` cycles (E1..E14).
  - At E15 the byte index is set to 0 and the FSM enters START; `tx`=0 from E15.
- Byte sequence, index 0..8:
  - `0x30`+d4, `0x30`+d3, `0x30`+d2, `0x30`+d1, `0x30`+d0
  - `0x2C`
  - `0x30`+`num_veh`
  - `0x0D`, `0x0A`
- Bit timing:
  - START, each of the 8 DATA bits (LSB first), and STOP each last exactly `CLKS_PER_BIT` cycles.
  - A baud counter runs from 0 to `CLKS_PER_BIT`-1 and rolls over at bit end.
  - Bytes are sent back-to-back: after STOP of byte k<8, START of byte k+1 follows with no idle gap.
- End of record (last cycle of byte 8 STOP):
  - If `pend_valid`=1, the next edge moves pending into the active registers, clears `pend_valid`, enters CONV; `busy` stays 1.
  - Otherwise go to IDLE and `busy`=0 at that edge.
- Simultaneous events:
  - `done` on the same edge as end of record counts as a non-IDLE capture. It goes to pending and is then consumed as above, so no frame is lost.
  - `done` while `reset`=1 is ignored.
- Width rules:
  - BCD shift register is 20 bits plus `WIDTH_SPEED` bits.
  - Add-3 correction is applied per nibble when the nibble is ≥5, before each shift.
  - `speed`=0 is sent as "00000".

Decomposition:
- Shared package `speed_pkg` holds:
  - ASCII constants (`ASCII_0`, `ASCII_COMMA`, `ASCII_CR`, `ASCII_LF`),
  - the record length (9),
  - the FSM state encoding,
  - a function computing `CLKS_PER_BIT`.
- One sub-module, `bin2bcd_seq`: start/done handshake, `WIDTH_SPEED`-cycle latency, 5 BCD digit outputs.
- The UART bit serializer stays inline in `speed_uart_tx`.

Test Plan:
All scenarios use `SYS_FREQ`=1000 and `BAUD`=100, so `CLKS_PER_BIT`=10.
1. `speed`=120, `num_veh`=1, `done` pulse from IDLE -> `tx` falls 15 cycles later; decoded bytes are 30 30 31 32 30 2C 31 0D 0A; `busy` is high for 15+9·100 cycles, then low.
2. `speed`=16383, `num_veh`=3 -> "16383,3\r\n"; `speed`=0, `num_veh`=0 -> "00000,0\r\n".
3. `done`(A=50) then, mid-record, `done`(B=75) -> record A complete, then record B with no IDLE gap and `busy` continuously 1; `drop` never pulses.
4. During record A, `done`(B=75) then `done`(C=90) -> `drop` pulses once on the C edge; records sent are A then C, and B is never sent.
5. `done` coincident with the last STOP cycle of a record -> the new record starts CONV on the next edge; the frame is not lost.
6. `reset` asserted during DATA of byte 3 -> `tx`=1 and `busy`=0 immediately (asynchronous), pending cleared. After release, a new `done` produces a full, correct record.
